// File: rtl/player_proj_controller_pkg.sv
// Shared game constants: playfield geometry, player/projectile sizes and
// the bus widths used by the player and projectile controllers.
package player_proj_controller_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int NUM_SLOTS    = 3;

    localparam int PLAYER_Y     = 440;
    localparam int PLAYER_W     = 32;
    localparam int PROJ_W       = 4;
    localparam int PROJ_H       = 8;
    localparam int PROJ_STEP    = 4;
    localparam int TOP_BOUNDARY = 0;
    localparam int COOLDOWN     = 8;

    localparam int CD_W         = $clog2(COOLDOWN + 1);

    // Projectiles leave the muzzle just above the player's top edge.
    localparam logic [Y_W-1:0] SPAWN_Y  = Y_W'(PLAYER_Y - PROJ_H);
    // Any Y below this cannot take another full step without crossing the top.
    localparam logic [Y_W-1:0] RETIRE_Y = Y_W'(TOP_BOUNDARY + PROJ_STEP);
    localparam logic [Y_W-1:0] STEP_Y   = Y_W'(PROJ_STEP);

    // Muzzle X: projectile centred on the player, wrapping at X_W bits.
    function automatic logic [X_W-1:0] spawn_x(input logic [X_W-1:0] player_x);
        return player_x + X_W'((PLAYER_W - PROJ_W) / 2);
    endfunction

endpackage

// File: rtl/player_proj_controller_proj_slot.sv
// One projectile slot: loads on spawn, climbs on each step, and clears on a
// hit or when it would cross the top boundary. Idle slots read as X=0, Y=0.
module proj_slot
    import player_proj_controller_pkg::*;
(
    input  logic           clk_master,
    input  logic           rst,
    input  logic           load,
    input  logic [X_W-1:0] loadX,
    input  logic [Y_W-1:0] loadY,
    input  logic           hit,
    input  logic           step,
    output logic           active,
    output logic [X_W-1:0] X,
    output logic [Y_W-1:0] Y
);

    logic           active_q, active_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    // Next state: live slots react to hit/step only; free slots accept a load.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        if (active_q) begin
            if (hit) begin
                active_d = 1'b0;
                x_d      = '0;
                y_d      = '0;
            end else if (step) begin
                if (y_q < RETIRE_Y) begin
                    active_d = 1'b0;
                    x_d      = '0;
                    y_d      = '0;
                end else begin
                    y_d = y_q - STEP_Y;
                end
            end
        end else if (load) begin
            active_d = 1'b1;
            x_d      = loadX;
            y_d      = loadY;
        end
    end

    // Slot state registers, cleared by reset even mid-flight.
    always_ff @(posedge clk_master) begin
        if (rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active = active_q;
    assign X      = x_q;
    assign Y      = y_q;

endmodule

// File: rtl/player_proj_controller.sv
// Player projectile stage: fire-edge detection, spawn cooldown, lowest-free
// slot selection, and three independent projectile slots.
module player_proj_controller
    import player_proj_controller_pkg::*;
(
    input  logic                 clk_master,
    input  logic                 rst,
    input  logic                 pulse_stepCycle,
    input  logic                 gameActive,
    input  logic                 fire,
    input  logic [X_W-1:0]       playerX,
    input  logic [NUM_SLOTS-1:0] projHit,
    output logic [NUM_SLOTS-1:0] projActive,
    output logic [X_W-1:0]       proj1X,
    output logic [X_W-1:0]       proj2X,
    output logic [X_W-1:0]       proj3X,
    output logic [Y_W-1:0]       proj1Y,
    output logic [Y_W-1:0]       proj2Y,
    output logic [Y_W-1:0]       proj3Y,
    output logic [X_W-1:0]       projW,
    output logic [Y_W-1:0]       projH
);

    logic                 fire_prev_q;
    logic [CD_W-1:0]      cooldown_q, cooldown_d;
    logic                 fire_req;
    logic                 spawn;
    logic [NUM_SLOTS-1:0] slot_active;
    logic [NUM_SLOTS-1:0] free_sel;
    logic [NUM_SLOTS-1:0] load_vec;
    logic [X_W-1:0]       slot_x [NUM_SLOTS];
    logic [Y_W-1:0]       slot_y [NUM_SLOTS];
    logic [X_W-1:0]       muzzle_x;

    assign fire_req = fire & ~fire_prev_q;
    assign spawn    = fire_req & gameActive & (cooldown_q == '0) & ~(&slot_active);
    assign muzzle_x = spawn_x(playerX);

    // Priority encoder: descending scan so the lowest free index wins.
    always_comb begin
        free_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_sel = NUM_SLOTS'(1) << i;
            end
        end
    end

    assign load_vec = spawn ? free_sel : '0;

    // Cooldown: a spawn reloads (and wins over a same-cycle step), steps count down to 0.
    always_comb begin
        cooldown_d = cooldown_q;
        if (spawn) begin
            cooldown_d = CD_W'(COOLDOWN);
        end else if (pulse_stepCycle && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
    end

    // Fire edge history and cooldown registers.
    always_ff @(posedge clk_master) begin
        if (rst) begin
            fire_prev_q <= 1'b0;
            cooldown_q  <= '0;
        end else begin
            fire_prev_q <= fire;
            cooldown_q  <= cooldown_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            proj_slot u_slot (
                .clk_master (clk_master),
                .rst        (rst),
                .load       (load_vec[gi]),
                .loadX      (muzzle_x),
                .loadY      (SPAWN_Y),
                .hit        (projHit[gi]),
                .step       (pulse_stepCycle),
                .active     (slot_active[gi]),
                .X          (slot_x[gi]),
                .Y          (slot_y[gi])
            );
        end
    endgenerate

    assign projActive = slot_active;
    assign proj1X     = slot_x[0];
    assign proj2X     = slot_x[1];
    assign proj3X     = slot_x[2];
    assign proj1Y     = slot_y[0];
    assign proj2Y     = slot_y[1];
    assign proj3Y     = slot_y[2];
    assign projW      = X_W'(PROJ_W);
    assign projH      = Y_W'(PROJ_H);

endmodule

// File: tb/tb_player_proj_controller.sv
// Bench for player_proj_controller: a cycle-level reference model in plain
// integers checked every cycle, plus hand-computed literal expectations.
module tb_player_proj_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_stepCycle;
    logic       gameActive;
    logic       fire;
    logic [9:0] playerX;
    logic [2:0] projHit;
    logic [2:0] projActive;
    logic [9:0] proj1X, proj2X, proj3X;
    logic [8:0] proj1Y, proj2Y, proj3Y;
    logic [9:0] projW;
    logic [8:0] projH;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    int m_act [3];
    int m_x   [3];
    int m_y   [3];
    int m_cd;
    int m_fprev;

    always #5 clk = ~clk;

    player_proj_controller dut (
        .clk_master      (clk),
        .rst             (rst),
        .pulse_stepCycle (pulse_stepCycle),
        .gameActive      (gameActive),
        .fire            (fire),
        .playerX         (playerX),
        .projHit         (projHit),
        .projActive      (projActive),
        .proj1X          (proj1X),
        .proj2X          (proj2X),
        .proj3X          (proj3X),
        .proj1Y          (proj1Y),
        .proj2Y          (proj2Y),
        .proj3Y          (proj3Y),
        .projW           (projW),
        .projH           (projH)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update, one game rule at a time, from the inputs seen at the edge.
    always @(posedge clk) begin
        int first_free;
        int do_spawn;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd = 0;
            m_fprev = 0;
        end else begin
            first_free = -1;
            for (int i = 2; i >= 0; i--) if (m_act[i] == 0) first_free = i;
            do_spawn = (fire && !m_fprev && gameActive && m_cd == 0 && first_free >= 0) ? 1 : 0;
            for (int i = 0; i < 3; i++) begin
                if (m_act[i] != 0) begin
                    if (projHit[i]) begin
                        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                    end else if (pulse_stepCycle) begin
                        if (m_y[i] - 4 < 0) begin
                            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                        end else begin
                            m_y[i] = m_y[i] - 4;
                        end
                    end
                end
            end
            if (do_spawn != 0) begin
                m_act[first_free] = 1;
                m_x[first_free]   = (int'(playerX) + 14) % 1024;
                m_y[first_free]   = 440 - 8;
                m_cd = 8;
            end else if (pulse_stepCycle && m_cd > 0) begin
                m_cd = m_cd - 1;
            end
            m_fprev = fire ? 1 : 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_active0", int'(projActive[0]), m_act[0]);
            check("cyc_active1", int'(projActive[1]), m_act[1]);
            check("cyc_active2", int'(projActive[2]), m_act[2]);
            check("cyc_x1", int'(proj1X), m_x[0]);
            check("cyc_x2", int'(proj2X), m_x[1]);
            check("cyc_x3", int'(proj3X), m_x[2]);
            check("cyc_y1", int'(proj1Y), m_y[0]);
            check("cyc_y2", int'(proj2Y), m_y[1]);
            check("cyc_y3", int'(proj3Y), m_y[2]);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            pulse_stepCycle = 1'b1;
            @(negedge clk);
            pulse_stepCycle = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; pulse_stepCycle = 1'b0; gameActive = 1'b1;
        fire = 1'b0; playerX = 10'd0; projHit = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        $display("[tb] reset state");
        check("reset_active", int'(projActive), 0);
        check("reset_x1", int'(proj1X), 0);
        check("reset_y1", int'(proj1Y), 0);
        check("const_projW", int'(projW), 4);
        check("const_projH", int'(projH), 8);

        $display("[tb] spawn at playerX=100");
        playerX = 10'd100;
        fire_pulse();
        check("spawn_active", int'(projActive), 3'b001);
        check("spawn_x1", int'(proj1X), 114);
        check("spawn_y1", int'(proj1Y), 432);
        step(1);
        check("step_y1", int'(proj1Y), 428);

        $display("[tb] fire edge during cooldown");
        step(2);
        fire_pulse();
        check("cooldown_block", int'(projActive), 3'b001);
        step(5);
        $display("[tb] fire edge after cooldown, playerX=200");
        playerX = 10'd200;
        fire_pulse();
        check("cooldown_done_active", int'(projActive), 3'b011);
        check("cooldown_done_x2", int'(proj2X), 214);
        check("cooldown_done_y1", int'(proj1Y), 400);

        $display("[tb] hit slot 2 with a step");
        projHit = 3'b010; pulse_stepCycle = 1'b1;
        @(negedge clk);
        projHit = 3'b000; pulse_stepCycle = 1'b0;
        check("hit_active", int'(projActive), 3'b001);
        check("hit_y1", int'(proj1Y), 396);
        check("hit_x2", int'(proj2X), 0);
        check("hit_y2", int'(proj2Y), 0);

        $display("[tb] reset mid-flight");
        do_reset();
        check("midrst_active", int'(projActive), 0);
        check("midrst_x1", int'(proj1X), 0);
        check("midrst_y1", int'(proj1Y), 0);

        $display("[tb] fire held for 20 cycles with steps");
        fire = 1'b1; pulse_stepCycle = 1'b1;
        repeat (20) @(negedge clk);
        fire = 1'b0; pulse_stepCycle = 1'b0;
        check("held_active", int'(projActive), 3'b001);
        check("held_y1", int'(proj1Y), 356);

        $display("[tb] fill all three slots");
        do_reset();
        playerX = 10'd50; fire_pulse(); step(8);
        playerX = 10'd60; fire_pulse(); step(8);
        playerX = 10'd70; fire_pulse();
        check("full_active", int'(projActive), 3'b111);
        step(8);
        playerX = 10'd300; fire_pulse();
        check("full_fourth_active", int'(projActive), 3'b111);
        check("full_x1", int'(proj1X), 64);
        check("full_x2", int'(proj2X), 74);
        check("full_x3", int'(proj3X), 84);
        check("full_y3", int'(proj3Y), 400);

        $display("[tb] gameActive low blocks spawn");
        do_reset();
        gameActive = 1'b0;
        fire_pulse();
        check("inactive_game", int'(projActive), 0);
        gameActive = 1'b1;

        $display("[tb] climb to top and retire");
        fire_pulse();
        check("retire_spawn_x1", int'(proj1X), 314);
        pulse_stepCycle = 1'b1;
        repeat (108) @(negedge clk);
        check("top_y1", int'(proj1Y), 0);
        check("top_active", int'(projActive), 3'b001);
        @(negedge clk);
        pulse_stepCycle = 1'b0;
        check("retired_active", int'(projActive), 0);
        check("retired_x1", int'(proj1X), 0);
        check("retired_y1", int'(proj1Y), 0);

        $display("[tb] X wrap and hits on idle slots");
        do_reset();
        playerX = 10'd1020;
        fire_pulse();
        check("wrap_x1", int'(proj1X), 10);
        projHit = 3'b110;
        @(negedge clk);
        projHit = 3'b000;
        check("idle_hit_active", int'(projActive), 3'b001);
        projHit = 3'b001;
        @(negedge clk);
        projHit = 3'b000;
        check("hit_no_step_active", int'(projActive), 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
